// File: rtl/beat_pkg.sv
// beat_pkg: shared types and constants for the beat sequencer
// Contents: run/halt state enum, one-hot beat encodings, default counter width,
// and a one-hot validity check on a beat vector.
package beat_pkg;
    typedef enum logic {HALT, RUN} beat_state_t;
    localparam logic [2:0] W1_OH = 3'b001;
    localparam logic [2:0] W2_OH = 3'b010;
    localparam logic [2:0] W3_OH = 3'b100;
    localparam int CNT_W_DEF = 16;
    function automatic logic is_onehot(input logic [2:0] w);
        return (w == W1_OH) || (w == W2_OH) || (w == W3_OH);
    endfunction
endpackage

// File: rtl/qd_edge_sync.sv
// qd_edge_sync: SYNC-deep synchronizer plus rising-edge detector with synchronous clear
// Ports: i_clk clock, i_clr sync active-high clear, i_d async level in,
//        o_rise one-cycle pulse on a synchronized 0->1 transition.
module qd_edge_sync #(
    parameter int SYNC = 2
) (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_d,
    output logic o_rise
);
    logic [SYNC-1:0] r_sync;
    logic [SYNC-1:0] r_vld;
    logic            r_prev;
    // r_vld tracks which sync stages hold post-clear samples; until the last
    // stage is real, r_prev is held high so a button held through clear is
    // never mistaken for a press.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_sync <= '0;
            r_vld  <= '0;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC-2:0], i_d};
            r_vld  <= {r_vld[SYNC-2:0], 1'b1};
            r_prev <= r_vld[SYNC-1] ? r_sync[SYNC-1] : 1'b1;
        end
    end
    assign o_rise = r_sync[SYNC-1] & ~r_prev;
endmodule

// File: rtl/beat_gen.sv
// beat_gen: one-hot machine-cycle beat sequencer with run/halt control and cycle counter
// Ports: T3 clock, CLR sync active-high reset, QD async start button,
//        SHORT/LONG/STOP controller feedback, STEP_MODE single-beat (BEAT_STEP_EN only),
//        W one-hot beats [3:1], RUNNING run state, CYC_CNT completed machine cycles.
// Optional feature macro: BEAT_STEP_EN adds the STEP_MODE port.
module beat_gen
    import beat_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int QD_SYNC = 2
) (
    input  logic             T3,
    input  logic             CLR,
    input  logic             QD,
    input  logic             SHORT,
    input  logic             LONG,
    input  logic             STOP,
`ifdef BEAT_STEP_EN
    input  logic             STEP_MODE,
`endif
    output logic [3:1]       W,
    output logic             RUNNING,
    output logic [CNT_W-1:0] CYC_CNT
);
    beat_state_t      r_state;
    beat_state_t      w_state_nxt;
    logic [2:0]       r_w;
    logic [2:0]       w_w_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_cnt_inc;
    logic             w_rise;
    logic             w_step;

`ifdef BEAT_STEP_EN
    assign w_step = STEP_MODE;
`else
    assign w_step = 1'b0;
`endif

    // Any non-one-hot beat falls through to W1.
    function automatic logic [2:0] next_beat(input logic [2:0] w, input logic s, input logic l);
        return (w == W1_OH) ? (s ? W1_OH : W2_OH) :
               (w == W2_OH) ? (l ? W3_OH : W1_OH) : W1_OH;
    endfunction

    qd_edge_sync #(.SYNC(QD_SYNC)) u_qd (
        .i_clk (T3),
        .i_clr (CLR),
        .i_d   (QD),
        .o_rise(w_rise)
    );

    always_ff @(posedge T3) begin
        if (CLR) begin
            r_state <= HALT;
            r_w     <= W1_OH;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_w     <= w_w_nxt;
            r_cnt   <= r_cnt + CNT_W'(w_cnt_inc);
        end
    end

    // A STOP in RUN beats a simultaneous QD rise because RUN ignores w_rise.
    always_comb begin
        w_state_nxt = r_state;
        w_w_nxt     = r_w;
        w_cnt_inc   = 1'b0;
        if (r_state == RUN) begin
            w_w_nxt     = next_beat(r_w, SHORT, LONG);
            w_cnt_inc   = (w_w_nxt == W1_OH);
            w_state_nxt = (STOP | w_step) ? HALT : RUN;
        end else begin
            w_w_nxt     = is_onehot(r_w) ? r_w : W1_OH;
            w_state_nxt = w_rise ? RUN : HALT;
        end
    end

    assign W       = r_w;
    assign RUNNING = (r_state == RUN);
    assign CYC_CNT = r_cnt;
endmodule

// File: tb/tb_beat_gen.sv
// tb_beat_gen: directed and randomized checks of beat_gen against a behavioural model
module tb_beat_gen;
    logic       T3 = 1'b0;
    logic       clr, qd, sh, lg, st;
    logic       step = 1'b0;
    logic [3:1] W;
    logic       RUNNING;
    logic [3:0] CYC_CNT;
    int         total = 0;
    int         bad = 0;

    always #5 T3 = ~T3;

    beat_gen #(.CNT_W(4), .QD_SYNC(2)) dut (
        .T3(T3), .CLR(clr), .QD(qd), .SHORT(sh), .LONG(lg), .STOP(st),
`ifdef BEAT_STEP_EN
        .STEP_MODE(step),
`endif
        .W(W), .RUNNING(RUNNING), .CYC_CNT(CYC_CNT)
    );

    // Model: beat number 1..3, run flag, count mod 16, and the list of QD
    // samples taken since the last clear. A press sampled high at post-clear
    // edge n, with edge n-1 sampled low, starts RUN at edge n+2.
    int  m_beat = 1;
    bit  m_run = 0;
    int  m_cnt = 0;
    bit  m_ok = 0;
    bit  qs[$];

    always @(posedge T3) begin
        int  k;
        int  nb;
        bit  rise;
        if (clr) begin
            m_beat = 1; m_run = 0; m_cnt = 0; m_ok = 1;
            qs.delete();
        end else begin
            k = qs.size() + 1;
            rise = (k >= 4) && qs[k-3] && !qs[k-4];
            if (!m_run) m_run = rise;
            else begin
                if (m_beat == 1) nb = sh ? 1 : 2;
                else if (m_beat == 2) nb = lg ? 3 : 1;
                else nb = 1;
                if (nb == 1) m_cnt = (m_cnt + 1) % 16;
                m_beat = nb;
                if (st || step) m_run = 0;
            end
            qs.push_back(qd);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge T3) begin
        if (m_ok) begin
            chk("model_w", 32'(W), 32'(1 << (m_beat - 1)));
            chk("model_running", 32'(RUNNING), 32'(m_run));
            chk("model_cnt", 32'(CYC_CNT), 32'(m_cnt));
        end
    end

    task automatic tk(input int n);
        repeat (n) begin
            @(posedge T3);
            #1;
        end
    endtask

    initial begin
        clr = 1; qd = 0; sh = 0; lg = 0; st = 0;
        tk(2);
        chk("rst_w", 32'(W), 1);
        chk("rst_running", 32'(RUNNING), 0);
        chk("rst_cnt", 32'(CYC_CNT), 0);
        clr = 0;
        tk(3);
        qd = 1;
        tk(1); chk("start_n", 32'(RUNNING), 0);
        tk(1); chk("start_n1", 32'(RUNNING), 0);
        tk(1); chk("start_n2", 32'(RUNNING), 1); chk("start_w_n2", 32'(W), 1);
        tk(1); chk("start_w_n3", 32'(W), 2);
        tk(1); chk("start_w_ret", 32'(W), 1); chk("start_cnt", 32'(CYC_CNT), 1);
        sh = 1;
        repeat (5) begin
            tk(1); chk("short_w", 32'(W), 1);
        end
        chk("short_cnt", 32'(CYC_CNT), 6);
        sh = 0; lg = 1;
        tk(1); chk("long_w2", 32'(W), 2);
        tk(1); chk("long_w3", 32'(W), 4);
        lg = 0; sh = 1;
        tk(1); chk("long_w1", 32'(W), 1); chk("long_cnt", 32'(CYC_CNT), 7);
        sh = 0;
        tk(1); chk("stop_pre_w", 32'(W), 2);
        st = 1;
        tk(1); chk("stop_w", 32'(W), 1); chk("stop_running", 32'(RUNNING), 0);
        chk("stop_cnt", 32'(CYC_CNT), 8);
        st = 0;
        tk(3); chk("stop_hold_w", 32'(W), 1); chk("stop_hold_running", 32'(RUNNING), 0);
        qd = 0; tk(2); qd = 1; tk(3);
        chk("restart_running", 32'(RUNNING), 1);
        lg = 1;
        tk(1); chk("clr_pre_w2", 32'(W), 2);
        tk(1); chk("clr_pre_w3", 32'(W), 4);
        lg = 0; clr = 1;
        tk(1); chk("clr_w", 32'(W), 1); chk("clr_cnt", 32'(CYC_CNT), 0);
        chk("clr_running", 32'(RUNNING), 0);
        clr = 0;
        tk(6); chk("held_qd_no_start", 32'(RUNNING), 0);
        qd = 0; tk(2); qd = 1; tk(3);
        chk("wrap_start", 32'(RUNNING), 1);
        sh = 1;
        tk(15); chk("wrap_15", 32'(CYC_CNT), 15);
        tk(1); chk("wrap_0", 32'(CYC_CNT), 0); chk("wrap_w", 32'(W), 1);
        sh = 0;
`ifdef BEAT_STEP_EN
        clr = 1; tk(1); clr = 0; qd = 0; step = 1; tk(3);
        for (int p = 0; p < 3; p++) begin
            qd = 1;
            tk(2); chk("step_idle", 32'(RUNNING), 0);
            tk(1); chk("step_run", 32'(RUNNING), 1);
            tk(1); chk("step_halt", 32'(RUNNING), 0);
            chk("step_w", 32'(W), (p == 1) ? 1 : 2);
            qd = 0; tk(2);
        end
        step = 0;
`endif
        repeat (3000) begin
            clr = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0) qd = ~qd;
            sh = ($urandom_range(0, 3) == 0);
            lg = ($urandom_range(0, 2) == 0);
            st = ($urandom_range(0, 15) == 0);
`ifdef BEAT_STEP_EN
            step = ($urandom_range(0, 7) == 0);
`endif
            tk(1);
        end
        tk(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
